// File: rtl/ihex_decoder.sv
// Streaming Intel HEX parser: one ASCII character per we_in strobe, emits one
// (address, byte) write per data byte through a one-entry holding register.
module ihex_decoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        we_in,
  input  logic [7:0]  data_in,
  input  logic        write_done,
  output logic        we_out,
  output logic [7:0]  data_out,
  output logic [31:0] address_out,
  output logic [31:0] start_address,
  output logic        end_of_file,
  output logic        line_error
);

  // state    | meaning
  // S_IDLE   | waiting for ':'
  // S_COUNT  | byte count field
  // S_ADDR_HI| load offset high byte
  // S_ADDR_LO| load offset low byte
  // S_TYPE   | record type field
  // S_DATA   | data bytes
  // S_CKSUM  | checksum byte
  // S_SKIP   | malformed record, waiting for ':'
  // S_DONE   | EOF seen, input ignored until reset
  typedef enum logic [3:0] {
    S_IDLE, S_COUNT, S_ADDR_HI, S_ADDR_LO, S_TYPE, S_DATA, S_CKSUM, S_SKIP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [3:0]  hi_nib_q, hi_nib_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] val_q, val_d;
  logic [31:0] base_q, base_d;
  logic [31:0] start_q, start_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic        full_q, full_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic [31:0] hold_addr_q, hold_addr_d;

  logic        is_hex;
  logic [3:0]  nib;
  logic [7:0]  byte_val;
  logic [7:0]  sum_next;
  logic        type_ok;
  logic [15:0] offset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      hi_nib_q    <= 4'h0;
      count_q     <= 8'h00;
      addr_q      <= 16'h0000;
      type_q      <= 8'h00;
      idx_q       <= 8'h00;
      sum_q       <= 8'h00;
      val_q       <= 32'h0;
      base_q      <= 32'h0;
      start_q     <= 32'h0;
      eof_q       <= 1'b0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
      hold_data_q <= 8'h00;
      hold_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_nib_q    <= hi_nib_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      type_q      <= type_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      val_q       <= val_d;
      base_q      <= base_d;
      start_q     <= start_d;
      eof_q       <= eof_d;
      err_q       <= err_d;
      full_q      <= full_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  // Character decode; letters share the low-nibble trick ('A'/'a' low nibble is 1).
  always_comb begin
    is_hex = 1'b1;
    nib    = 4'h0;
    if (data_in >= 8'h30 && data_in <= 8'h39)
      nib = data_in[3:0];
    else if ((data_in >= 8'h41 && data_in <= 8'h46) || (data_in >= 8'h61 && data_in <= 8'h66))
      nib = data_in[3:0] + 4'd9;
    else
      is_hex = 1'b0;
    byte_val = {hi_nib_q, nib};
    sum_next = sum_q + byte_val;
    offset   = addr_q + {8'h00, idx_q};
    case (byte_val)
      8'h00:        type_ok = 1'b1;
      8'h01:        type_ok = (count_q == 8'd0);
      8'h02, 8'h04: type_ok = (count_q == 8'd2);
      8'h03, 8'h05: type_ok = (count_q == 8'd4);
      default:      type_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_nib_d    = hi_nib_q;
    count_d     = count_q;
    addr_d      = addr_q;
    type_d      = type_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    val_d       = val_q;
    base_d      = base_q;
    start_d     = start_q;
    eof_d       = eof_q;
    err_d       = err_q;
    full_d      = full_q & ~write_done;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;

    if (we_in && state_q != S_DONE) begin
      if (data_in == 8'h3A) begin
        state_d = S_COUNT;
        err_d   = 1'b0;
        sum_d   = 8'h00;
        phase_d = 1'b0;
      end else if (state_q == S_IDLE || state_q == S_SKIP) begin
        state_d = state_q;
      end else if (!is_hex) begin
        err_d   = 1'b1;
        state_d = S_SKIP;
      end else if (!phase_q) begin
        hi_nib_d = nib;
        phase_d  = 1'b1;
      end else begin
        phase_d = 1'b0;
        sum_d   = sum_next;
        case (state_q)
          S_COUNT: begin
            count_d = byte_val;
            state_d = S_ADDR_HI;
          end
          S_ADDR_HI: begin
            addr_d[15:8] = byte_val;
            state_d      = S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr_d[7:0] = byte_val;
            state_d     = S_TYPE;
          end
          S_TYPE: begin
            type_d = byte_val;
            idx_d  = 8'h00;
            val_d  = 32'h0;
            if (!type_ok) begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end else if (count_q == 8'd0) begin
              state_d = S_CKSUM;
            end else begin
              state_d = S_DATA;
            end
          end
          S_DATA: begin
            // A byte landing on a still-blocked holding register is dropped.
            if (type_q == 8'h00 && full_q && !write_done) begin
              err_d   = 1'b1;
              state_d = S_SKIP;
            end else begin
              if (type_q == 8'h00) begin
                full_d      = 1'b1;
                hold_data_d = byte_val;
                hold_addr_d = base_q + {16'h0000, offset};
              end
              val_d = {val_q[23:0], byte_val};
              idx_d = idx_q + 8'd1;
              if ({1'b0, idx_q} + 9'd1 == {1'b0, count_q})
                state_d = S_CKSUM;
            end
          end
          S_CKSUM: begin
            state_d = S_IDLE;
            if (sum_next != 8'h00) begin
              err_d = 1'b1;
            end else begin
              case (type_q)
                8'h01: begin
                  eof_d   = 1'b1;
                  state_d = S_DONE;
                end
                8'h02:        base_d  = {12'h000, val_q[15:0], 4'h0};
                8'h04:        base_d  = {val_q[15:0], 16'h0000};
                8'h03, 8'h05: start_d = val_q;
                default:      base_d  = base_q;
              endcase
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_comb begin
    we_out        = full_q & write_done;
    data_out      = hold_data_q;
    address_out   = hold_addr_q;
    start_address = start_q;
    end_of_file   = eof_q;
    line_error    = err_q;
  end

endmodule

// File: tb/tb_ihex_decoder.sv
// Directed bench for ihex_decoder: feeds HEX text, captures writes, checks against hand-computed values.
module tb_ihex_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        we_in = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        write_done = 1'b1;
  logic        we_out;
  logic [7:0]  data_out;
  logic [31:0] address_out;
  logic [31:0] start_address;
  logic        end_of_file;
  logic        line_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wa[$];
  logic [7:0]  wd[$];

  ihex_decoder dut (
    .clock(clock), .reset(reset), .we_in(we_in), .data_in(data_in),
    .write_done(write_done), .we_out(we_out), .data_out(data_out),
    .address_out(address_out), .start_address(start_address),
    .end_of_file(end_of_file), .line_error(line_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (we_out === 1'b1) begin
      wa.push_back(address_out);
      wd.push_back(data_out);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    we_in = 1'b0;
    write_done = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic send_char(input byte c);
    we_in = 1'b1;
    data_in = c;
    @(posedge clock);
    #1;
    we_in = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_cmp += 6;
    if (we_out !== 1'b0) begin n_bad++; $display("FAIL reset_we_out: got %b want 0", we_out); end
    if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    if (address_out !== 32'h0) begin n_bad++; $display("FAIL reset_address_out: got %h want 0", address_out); end
    if (start_address !== 32'h0) begin n_bad++; $display("FAIL reset_start: got %h want 0", start_address); end
    if (end_of_file !== 1'b0) begin n_bad++; $display("FAIL reset_eof: got %b want 0", end_of_file); end
    if (line_error !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", line_error); end
  endtask

  task automatic test_data_eof();
    logic [31:0] ea [3] = '{32'h30, 32'h31, 32'h32};
    logic [7:0]  ed [3] = '{8'h02, 8'h33, 8'h7A};
    do_reset();
    send_str(":0300300002337A1E\r\n:00000001FF\r\n");
    idle(2);
    n_cmp++;
    if (wa.size() != 3) begin n_bad++; $display("FAIL data_count: got %0d want 3", wa.size()); end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      n_cmp++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        n_bad++;
        $display("FAIL data_write%0d: got %h:%h want %h:%h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
    n_cmp += 2;
    if (end_of_file !== 1'b1) begin n_bad++; $display("FAIL data_eof: got %b want 1", end_of_file); end
    if (line_error !== 1'b0) begin n_bad++; $display("FAIL data_err: got %b want 0", line_error); end
  endtask

  task automatic test_ext_linear();
    do_reset();
    send_str(":020000040800F2:010000005");
    send_char("5");
    n_cmp++;
    if (we_out !== 1'b1) begin n_bad++; $display("FAIL lin_we_timing: got %b want 1", we_out); end
    idle(1);
    n_cmp++;
    if (we_out !== 1'b0) begin n_bad++; $display("FAIL lin_we_single: got %b want 0", we_out); end
    send_str("AA");
    idle(2);
    n_cmp++;
    if (wa.size() != 1) begin n_bad++; $display("FAIL lin_count: got %0d want 1", wa.size()); end
    else begin
      n_cmp++;
      if (wa[0] !== 32'h08000000 || wd[0] !== 8'h55) begin
        n_bad++; $display("FAIL lin_write: got %h:%h want 08000000:55", wa[0], wd[0]);
      end
    end
  endtask

  task automatic test_segment_wrap();
    do_reset();
    send_str(":020000021000EC\n:02FFFF001122CD\n");
    idle(2);
    n_cmp++;
    if (wa.size() != 2) begin n_bad++; $display("FAIL seg_count: got %0d want 2", wa.size()); end
    else begin
      n_cmp += 2;
      if (wa[0] !== 32'h0001FFFF || wd[0] !== 8'h11) begin
        n_bad++; $display("FAIL seg_write0: got %h:%h want 0001ffff:11", wa[0], wd[0]);
      end
      if (wa[1] !== 32'h00010000 || wd[1] !== 8'h22) begin
        n_bad++; $display("FAIL seg_write1: got %h:%h want 00010000:22", wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_bad_cksum();
    do_reset();
    send_str(":0100000055A");
    n_cmp++;
    if (line_error !== 1'b0) begin n_bad++; $display("FAIL ck_err_early: got %b want 0", line_error); end
    send_char("B");
    n_cmp++;
    if (line_error !== 1'b1) begin n_bad++; $display("FAIL ck_err_set: got %b want 1", line_error); end
    idle(1);
    n_cmp++;
    if (wa.size() != 1 || wd[0] !== 8'h55 || wa[0] !== 32'h0) begin
      n_bad++; $display("FAIL ck_write: got %0d writes want 1 of 00000000:55", wa.size());
    end
    send_str("\r\n");
    send_char(":");
    n_cmp++;
    if (line_error !== 1'b0) begin n_bad++; $display("FAIL ck_err_clear: got %b want 0", line_error); end
    send_str("00000001FF");
    n_cmp++;
    if (end_of_file !== 1'b1) begin n_bad++; $display("FAIL ck_eof: got %b want 1", end_of_file); end
  endtask

  task automatic test_start_linear();
    do_reset();
    send_str(":0400000508000131BD\n");
    idle(2);
    n_cmp += 3;
    if (start_address !== 32'h08000131) begin n_bad++; $display("FAIL st_value: got %h want 08000131", start_address); end
    if (wa.size() != 0) begin n_bad++; $display("FAIL st_nowrite: got %0d writes want 0", wa.size()); end
    if (line_error !== 1'b0) begin n_bad++; $display("FAIL st_err0: got %b want 0", line_error); end
    send_str(":04000005080001G");
    n_cmp++;
    if (line_error !== 1'b1) begin n_bad++; $display("FAIL st_err_g: got %b want 1", line_error); end
    send_str("1BD\n");
    idle(1);
    n_cmp += 2;
    if (start_address !== 32'h08000131) begin n_bad++; $display("FAIL st_unchanged: got %h want 08000131", start_address); end
    if (line_error !== 1'b1) begin n_bad++; $display("FAIL st_err_hold: got %b want 1", line_error); end
  endtask

  task automatic test_write_stall();
    int seen;
    do_reset();
    write_done = 1'b0;
    send_str(":0100000055AA");
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      if (we_out !== 1'b0) seen++;
      idle(1);
    end
    n_cmp += 2;
    if (seen != 0 || wa.size() != 0) begin n_bad++; $display("FAIL stall_no_we: got %0d strobes want 0", seen); end
    if (line_error !== 1'b0) begin n_bad++; $display("FAIL stall_err: got %b want 0", line_error); end
    write_done = 1'b1;
    idle(3);
    n_cmp++;
    if (wa.size() != 1) begin n_bad++; $display("FAIL stall_count: got %0d want 1", wa.size()); end
    else begin
      n_cmp++;
      if (wa[0] !== 32'h0 || wd[0] !== 8'h55) begin
        n_bad++; $display("FAIL stall_write: got %h:%h want 00000000:55", wa[0], wd[0]);
      end
    end
    send_str(":00000001FF:0100000055AA:0300300002337A1E");
    idle(3);
    n_cmp += 3;
    if (end_of_file !== 1'b1) begin n_bad++; $display("FAIL post_eof: got %b want 1", end_of_file); end
    if (wa.size() != 1) begin n_bad++; $display("FAIL post_eof_writes: got %0d want 1", wa.size()); end
    if (line_error !== 1'b0) begin n_bad++; $display("FAIL post_eof_err: got %b want 0", line_error); end
  endtask

  task automatic test_overflow();
    do_reset();
    write_done = 1'b0;
    send_str(":02000000112");
    n_cmp++;
    if (line_error !== 1'b0) begin n_bad++; $display("FAIL ovf_err_early: got %b want 0", line_error); end
    send_char("2");
    n_cmp++;
    if (line_error !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", line_error); end
    write_done = 1'b1;
    idle(3);
    n_cmp++;
    if (wa.size() != 1 || wd[0] !== 8'h11) begin
      n_bad++; $display("FAIL ovf_write: got %0d writes want 1 of 00000000:11", wa.size());
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    write_done = 1'b0;
    send_str(":0100000055");
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    write_done = 1'b1;
    idle(3);
    n_cmp++;
    if (wa.size() != 0) begin n_bad++; $display("FAIL abort_nowrite: got %0d writes want 0", wa.size()); end
  endtask

  initial begin
    test_reset();
    test_data_eof();
    test_ext_linear();
    test_segment_wrap();
    test_bad_cksum();
    test_start_linear();
    test_write_stall();
    test_overflow();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ihex_decoder.md
# ihex_decoder

Streaming Intel HEX parser. It accepts the ASCII text of a .hex file one character per write strobe, decodes each record, and emits one (address, byte) write per data byte to a downstream memory writer. It also tracks the start address and flags end-of-file and per-line errors. It sits between a character source (UART or file reader) and a memory/flash programming port.

## Interface
Parameters: none.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- we_in  in  1  one-cycle strobe: data_in holds a valid character
- data_in  in  8  ASCII character
- write_done  in  1  level; downstream can accept a write this cycle
- we_out  out  1  one-cycle write strobe
- data_out  out  8  byte to write (valid with we_out)
- address_out  out  32  target address (valid with we_out)
- start_address  out  32  last committed type-03/05 value
- end_of_file  out  1  sticky; a valid type-01 record was received
- line_error  out  1  current/last record was malformed

## Operation
- States:
  - IDLE: wait for ':'; all other characters ignored.
  - COUNT, ADDR_HI, ADDR_LO, TYPE, DATA, CKSUM: each consumes two hex digits per byte.
  - SKIP: error; wait for ':'.
  - DONE: after EOF; ignore all input.
- Hex digits accepted: 0-9, A-F, a-f. Any other character inside a record sets line_error and enters SKIP.
- ':' in any state except DONE starts a new record, clears line_error and resets the running sum.
- After CKSUM, return to IDLE. CR, LF and other characters there are ignored.
- Checksum: the 8-bit sum of all record bytes including the checksum must be 0x00. On mismatch, set line_error and make no commit.
- Record types and required byte counts:
  - 00 data: any count 0..255.
  - 01 EOF: count 0.
  - 02 extended segment: count 2.
  - 03 start segment: count 4.
  - 04 extended linear: count 2.
  - 05 start linear: count 4.
  - Wrong count or any other type sets line_error and enters SKIP.
- Base register (32-bit, reset 0):
  - Type 02 value V commits base = V<<4.
  - Type 04 commits base = V<<16.
  - Commits happen only after a good checksum.
- Data bytes: byte i of a type-00 record at load offset O is written to address_out = base + ((O+i) mod 2^16). Bytes are emitted as soon as decoded, before the checksum is checked. A bad checksum flags line_error, but already-written bytes are not retracted.
- Write handshake:
  - A decoded byte enters a one-entry holding register.
  - we_out pulses in the first cycle write_done is high while the register is full; the register empties that cycle.
  - If a new byte completes while the register is still full, set line_error, drop the new byte, and enter SKIP.
- Types 03/05: the four data bytes, big-endian {b0,b1,b2,b3}, commit to start_address after a good checksum. No segment arithmetic is applied.
- Type 01 with a good checksum sets end_of_file and enters DONE. Only reset leaves DONE.

## Timing
- Reset values: all outputs 0; state IDLE; base 0; holding register empty.
- Each we_in strobe is processed in the cycle it is sampled. The decoder does not stall input; characters may arrive back-to-back every cycle.
- we_out is asserted the cycle after the we_in carrying a data byte's second digit, when write_done is high.
- line_error, end_of_file, start_address and base update the cycle after the we_in carrying the final checksum digit, or the offending character.
- we_out is never asserted in consecutive cycles for the same byte. address_out and data_out are held until the next write.
- Reset asserted mid-record aborts the record immediately; a pending write is discarded.

## Test plan
- ":0300300002337A1E" then ":00000001FF", write_done=1 -> writes 00000030:02, 00000031:33, 00000032:7A; end_of_file=1; line_error=0.
- ":020000040800F2" then ":0100000055AA" -> one write 08000000:55.
- ":020000021000EC" then ":02FFFF001122CD" -> writes 0001FFFF:11, 00010000:22 (offset wraps).
- ":0100000055AB" -> write 00000000:55; line_error=1 after the final digit; a following good record clears line_error at its ':'.
- ":0400000508000131BD" -> start_address=08000131; no writes. Then ":04000005080001G1BD" -> line_error=1 at 'G'; start_address unchanged.
- write_done held low for 64 cycles during ":0100000055AA" -> we_out waits, then pulses once when write_done rises; characters received after EOF produce no writes.
